// File: rtl/sme_param.sv
// Parametrised string-match engine: buffers a string and a pattern from one byte stream,
// then scans one character compare per cycle with '.' wildcard and '^'/'$' anchors.
module sme_param #(
  parameter int                 CHAR_W     = 8,
  parameter int                 STR_MAX    = 32,
  parameter int                 PAT_MAX    = 8,
  parameter bit                 WORD_BOUND = 1'b1,
  parameter logic [CHAR_W-1:0]  WILD_CH    = 8'h2E,
  parameter logic [CHAR_W-1:0]  HEAD_CH    = 8'h5E,
  parameter logic [CHAR_W-1:0]  TAIL_CH    = 8'h24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHAR_W-1:0]           chardata,
  input  logic                        isstring,
  input  logic                        ispattern,
  output logic                        valid,
  output logic                        match,
  output logic [$clog2(STR_MAX)-1:0]  match_index
);

  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);
  // Common arithmetic width so string and pattern lengths compare without truncation.
  localparam int NW = ((SW > PW) ? SW : PW) + 2;

  localparam logic [SW:0]       SLEN_FULL = (SW+1)'(STR_MAX);
  localparam logic [PW:0]       PLEN_FULL = (PW+1)'(PAT_MAX);
  localparam logic [CHAR_W-1:0] SPACE_CH  = CHAR_W'(8'h20);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_S = 3'd1;
  localparam logic [2:0] S_LOAD_P = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SW:0]       slen_q, slen_d;
  logic [PW:0]       plen_q, plen_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [SW:0]       sp_q, sp_d;
  logic [PW:0]       pi_q, pi_d;
  logic              match_q, match_d;
  logic [SW-1:0]     idx_q, idx_d;

  logic [CHAR_W-1:0] str_mem [STR_MAX];
  logic [CHAR_W-1:0] pat_mem [PAT_MAX];

  logic              load_str, load_pat;
  logic              str_we, pat_we;
  logic [SW-1:0]     str_waddr;
  logic [PW-1:0]     pat_waddr;

  logic [NW-1:0]     slen_n, plen_n, sp_n, pi_n;
  logic [CHAR_W-1:0] cur_str, prev_str, next_str, cur_pat;
  logic              early_exit, last_pi, at_end;
  logic              char_ok, head_ok, tail_ok, cmp_pass;

  assign slen_n = NW'(slen_q);
  assign plen_n = NW'(plen_q);
  assign sp_n   = NW'(sp_q);
  assign pi_n   = NW'(pi_q);

  assign cur_str  = str_mem[SW'(sp_n + pi_n)];
  assign prev_str = str_mem[SW'(sp_n - NW'(1))];
  assign next_str = str_mem[SW'(sp_n + plen_n)];
  assign cur_pat  = pat_mem[PW'(pi_q)];

  assign early_exit = (plen_n == '0) || (plen_n > slen_n);
  assign last_pi    = (pi_n == plen_n - NW'(1));
  assign at_end     = (sp_n == slen_n - plen_n);

  // Anchor checks only bite at the first/last pattern position; reads past slen are masked.
  assign char_ok  = (cur_pat == WILD_CH) || (cur_pat == cur_str);
  assign head_ok  = !(head_q && (pi_q == '0)) || (sp_q == '0) ||
                    (WORD_BOUND && (prev_str == SPACE_CH));
  assign tail_ok  = !(tail_q && last_pi) || ((sp_n + plen_n) == slen_n) ||
                    (WORD_BOUND && (next_str == SPACE_CH));
  assign cmp_pass = char_ok && head_ok && tail_ok;

  always_comb begin
    state_d   = state_q;
    slen_d    = slen_q;
    plen_d    = plen_q;
    head_d    = head_q;
    tail_d    = tail_q;
    sp_d      = sp_q;
    pi_d      = pi_q;
    match_d   = match_q;
    idx_d     = idx_q;
    load_str  = 1'b0;
    load_pat  = 1'b0;
    str_we    = 1'b0;
    str_waddr = '0;
    pat_we    = 1'b0;
    pat_waddr = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (isstring) begin
          state_d  = S_LOAD_S;
          slen_d   = '0;
          plen_d   = '0;
          head_d   = 1'b0;
          tail_d   = 1'b0;
          load_str = 1'b1;
        end else if (ispattern) begin
          state_d  = S_LOAD_P;
          plen_d   = '0;
          head_d   = 1'b0;
          tail_d   = 1'b0;
          load_pat = 1'b1;
        end
      end
      S_LOAD_S: begin
        if (isstring) begin
          load_str = 1'b1;
        end else if (ispattern) begin
          state_d  = S_LOAD_P;
          load_pat = 1'b1;
        end
      end
      S_LOAD_P: begin
        if (ispattern && !isstring) begin
          load_pat = 1'b1;
        end else begin
          state_d = S_SCAN;
          sp_d    = '0;
          pi_d    = '0;
        end
      end
      S_SCAN: begin
        if (early_exit) begin
          state_d = S_DONE;
          match_d = 1'b0;
          idx_d   = '0;
        end else if (cmp_pass) begin
          if (last_pi) begin
            state_d = S_DONE;
            match_d = 1'b1;
            idx_d   = SW'(sp_q);
          end else begin
            pi_d = pi_q + (PW+1)'(1);
          end
        end else begin
          pi_d = '0;
          if (at_end) begin
            state_d = S_DONE;
            match_d = 1'b0;
            idx_d   = '0;
          end else begin
            sp_d = sp_q + (SW+1)'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Characters beyond buffer depth are dropped and the length saturates.
    if (load_str && (slen_d != SLEN_FULL)) begin
      str_we    = 1'b1;
      str_waddr = SW'(slen_d);
      slen_d    = slen_d + (SW+1)'(1);
    end

    if (load_pat) begin
      if (chardata == HEAD_CH) begin
        head_d = 1'b1;
      end else if (chardata == TAIL_CH) begin
        tail_d = 1'b1;
      end else if (plen_d != PLEN_FULL) begin
        pat_we    = 1'b1;
        pat_waddr = PW'(plen_d);
        plen_d    = plen_d + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      slen_q  <= '0;
      plen_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      sp_q    <= '0;
      pi_q    <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slen_q  <= slen_d;
      plen_q  <= plen_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      sp_q    <= sp_d;
      pi_q    <= pi_d;
      match_q <= match_d;
      idx_q   <= idx_d;
    end
  end

  // Buffers keep their contents across reset; only the lengths are cleared.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= chardata;
    if (pat_we) pat_mem[pat_waddr] <= chardata;
  end

  assign valid       = (state_q == S_DONE);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule
